// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI responder shift engine.
// Holds FSM state encoding, data width, underrun byte and bit helpers.
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam logic [SPI_DATA_W-1:0] SPI_TX_UNDERRUN = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT
  } spi_state_e;

  function automatic logic first_bit(
    input logic [SPI_DATA_W-1:0] d,
    input logic                  lsbfe
  );
    return lsbfe ? d[0] : d[SPI_DATA_W-1];
  endfunction

  function automatic logic [SPI_DATA_W-1:0] shift_out(
    input logic [SPI_DATA_W-1:0] d,
    input logic                  lsbfe
  );
    return lsbfe ? {1'b0, d[SPI_DATA_W-1:1]}
                 : {d[SPI_DATA_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with rise/fall pulses on the synchronized value.
// Ports: PCLK, PRESET_n, d (async in), q (synced), rise, fall (1-cycle pulses).
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic PCLK,
  input  logic PRESET_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              q_d;

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      sync <= {STAGES{RST_VAL}};
      q_d  <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      q_d  <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI responder shift engine: oversampled SCLK/SS/MOSI, 8-bit frames, all modes.
// Ports: PCLK/PRESET_n, mode (spe/cpol/cpha/lsbfe), SPI pins, tx holding reg, rx byte.
module spi_slave_shifter
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  PCLK,
  input  logic                  PRESET_n,
  input  logic                  spe_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  lsbfe_i,
  input  logic                  sclk_i,
  input  logic                  ss_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic                  miso_oe_o,
  input  logic [SPI_DATA_W-1:0] tx_data_i,
  input  logic                  tx_load_i,
  output logic                  tx_empty_o,
  output logic [SPI_DATA_W-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o
);

  logic sclk_q, sclk_rise, sclk_fall;
  logic ss_q, ss_rise, ss_fall;
  logic mosi_q, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .d(sclk_i),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  // SS idles high, so its chain resets high to avoid a phantom select.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .d(ss_i),
    .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .d(mosi_i),
    .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = &{1'b0, sclk_q, mosi_rise, mosi_fall};

  spi_state_e            state;
  logic [2:0]            bit_cnt;
  logic [SPI_DATA_W-1:0] hold, tx_sr, rx_sr;
  logic                  cpol_l, cpha_l, lsbfe_l;

  logic                  lead, trail, samp, drv;
  logic                  abort, reload, xfer;
  logic [SPI_DATA_W-1:0] rx_next, tx_next;

  always_comb begin
    lead    = cpol_l ? sclk_fall : sclk_rise;
    trail   = cpol_l ? sclk_rise : sclk_fall;
    samp    = cpha_l ? trail : lead;
    drv     = cpha_l ? lead : trail;
    abort   = !spe_i || ss_rise;
    reload  = (state == ST_SHIFT) && samp &&
              (bit_cnt == 3'd7) && !ss_q && !abort;
    xfer    = !abort && ((state == ST_LOAD) || reload);
    rx_next = lsbfe_l ? {mosi_q, rx_sr[SPI_DATA_W-1:1]}
                      : {rx_sr[SPI_DATA_W-2:0], mosi_q};
    tx_next = tx_empty_o ? SPI_TX_UNDERRUN : hold;
  end

  // Holding register: a transfer out of a full register wins over a
  // load, which is refused anyway because the register is full.
  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      hold       <= '0;
      tx_empty_o <= 1'b1;
    end else if (xfer && !tx_empty_o) begin
      tx_empty_o <= 1'b1;
    end else if (tx_load_i && tx_empty_o) begin
      hold       <= tx_data_i;
      tx_empty_o <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      miso_o     <= 1'b0;
      miso_oe_o  <= 1'b0;
      cpol_l     <= 1'b0;
      cpha_l     <= 1'b0;
      lsbfe_l    <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state     <= ST_IDLE;
        busy_o    <= 1'b0;
        miso_o    <= 1'b0;
        miso_oe_o <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (ss_fall) begin
              cpol_l  <= cpol_i;
              cpha_l  <= cpha_i;
              lsbfe_l <= lsbfe_i;
              if (spe_i) begin
                state  <= ST_LOAD;
                busy_o <= 1'b1;
              end
            end
          end
          ST_LOAD: begin
            bit_cnt   <= '0;
            miso_oe_o <= 1'b1;
            state     <= ST_SHIFT;
            if (!cpha_l) begin
              miso_o <= first_bit(tx_next, lsbfe_l);
              tx_sr  <= shift_out(tx_next, lsbfe_l);
            end else begin
              tx_sr  <= tx_next;
            end
          end
          ST_SHIFT: begin
            if (samp) begin
              rx_sr   <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data_o  <= rx_next;
                rx_valid_o <= 1'b1;
                // Reloaded byte stays unshifted: the next drive edge
                // (8th trailing for CPHA=0) presents its first bit.
                if (reload) begin
                  tx_sr   <= tx_next;
                  bit_cnt <= '0;
                end else begin
                  state     <= ST_IDLE;
                  busy_o    <= 1'b0;
                  miso_o    <= 1'b0;
                  miso_oe_o <= 1'b0;
                end
              end
            end else if (drv) begin
              miso_o <= first_bit(tx_sr, lsbfe_l);
              tx_sr  <= shift_out(tx_sr, lsbfe_l);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Scoreboard bench for spi_slave_shifter: directed SPI master frames.
// Expected rx bytes are queued at issue; a monitor checks each rx_valid pulse.
module tb_spi_slave_shifter;

  logic       PCLK = 1'b0;
  logic       PRESET_n = 1'b0;
  logic       spe_i = 1'b1;
  logic       cpol_i = 1'b0;
  logic       cpha_i = 1'b0;
  logic       lsbfe_i = 1'b0;
  logic       sclk_i = 1'b0;
  logic       ss_i = 1'b1;
  logic       mosi_i = 1'b0;
  logic       miso_o, miso_oe_o, tx_empty_o, rx_valid_o, busy_o;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_load_i = 1'b0;
  logic [7:0] rx_data_o;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] rx_q[$];

  spi_slave_shifter #(.SYNC_STAGES(2)) dut (
    .PCLK(PCLK), .PRESET_n(PRESET_n), .spe_i(spe_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i), .lsbfe_i(lsbfe_i),
    .sclk_i(sclk_i), .ss_i(ss_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o),
    .tx_data_i(tx_data_i), .tx_load_i(tx_load_i),
    .tx_empty_o(tx_empty_o), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .busy_o(busy_o)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge PCLK) begin
    if (PRESET_n && rx_valid_o) begin
      if (rx_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rx_unexpected: got %h expected none", rx_data_o);
      end else begin
        chk("rx_data", rx_data_o, rx_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge PCLK);
  endtask

  task automatic half();
    cyc(8);
  endtask

  task automatic set_mode(input logic pol, input logic pha,
                          input logic lsb);
    cpol_i = pol;
    cpha_i = pha;
    lsbfe_i = lsb;
    sclk_i = pol;
    cyc(4);
  endtask

  task automatic load(input logic [7:0] b);
    tx_data_i = b;
    tx_load_i = 1'b1;
    cyc(1);
    tx_load_i = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] b, input int nbits,
                      output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = lsbfe_i ? i : 7 - i;
      if (!cpha_i) begin
        mosi_i = b[idx];
        half();
        sclk_i = ~cpol_i;
        got[idx] = miso_o;
        half();
        sclk_i = cpol_i;
      end else begin
        half();
        sclk_i = ~cpol_i;
        mosi_i = b[idx];
        half();
        sclk_i = cpol_i;
        got[idx] = miso_o;
      end
    end
  endtask

  task automatic frame(input string nm, input logic [7:0] mo,
                       input logic [7:0] exp_mi, input int first);
    logic [7:0] got;
    ss_i = 1'b0;
    cyc(4);
    chk({nm, "_busy"}, {7'd0, busy_o}, 8'd1);
    chk({nm, "_oe"}, {7'd0, miso_oe_o}, 8'd1);
    if (first >= 0) chk({nm, "_first"}, {7'd0, miso_o}, 8'(first));
    rx_q.push_back(mo);
    xfer(mo, 8, got);
    chk({nm, "_miso"}, got, exp_mi);
    cyc(4);
    ss_i = 1'b1;
    cyc(6);
    chk({nm, "_idle"}, {7'd0, busy_o}, 8'd0);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_miso"}, {7'd0, miso_o}, 8'd0);
    chk({nm, "_oe"}, {7'd0, miso_oe_o}, 8'd0);
    chk({nm, "_empty"}, {7'd0, tx_empty_o}, 8'd1);
    chk({nm, "_rxd"}, rx_data_o, 8'h00);
    chk({nm, "_rxv"}, {7'd0, rx_valid_o}, 8'd0);
    chk({nm, "_busy"}, {7'd0, busy_o}, 8'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    cyc(3);
    chk_reset("reset");
    PRESET_n = 1'b1;
    cyc(4);

    // Mode 0, MSB first
    set_mode(1'b0, 1'b0, 1'b0);
    load(8'h3C);
    chk("load_full", {7'd0, tx_empty_o}, 8'd0);
    frame("m0", 8'hA5, 8'h3C, 0);

    // All four modes, LSB first, both byte directions
    for (int m = 0; m < 4; m++) begin
      set_mode(m[1], m[0], 1'b1);
      load(8'h80);
      frame("mode_a", 8'h01, 8'h80, -1);
      load(8'h01);
      frame("mode_b", 8'h80, 8'h01, m[0] ? 0 : 1);
    end

    // Back-to-back frames with SS held low
    set_mode(1'b0, 1'b0, 1'b0);
    load(8'h11);
    ss_i = 1'b0;
    cyc(6);
    load(8'h22);
    rx_q.push_back(8'h5A);
    xfer(8'h5A, 8, got);
    chk("b2b_1", got, 8'h11);
    rx_q.push_back(8'hC3);
    xfer(8'hC3, 8, got);
    chk("b2b_2", got, 8'h22);
    rx_q.push_back(8'h0F);
    xfer(8'h0F, 8, got);
    chk("b2b_under", got, 8'h00);
    cyc(4);
    ss_i = 1'b1;
    cyc(6);

    // Holding register: load while full is ignored
    load(8'h44);
    load(8'h55);
    chk("hs_full", {7'd0, tx_empty_o}, 8'd0);
    frame("hs_keep", 8'h99, 8'h44, -1);

    // Load coinciding with the LOAD transfer of an empty register
    ss_i = 1'b0;
    cyc(3);
    tx_data_i = 8'h66;
    tx_load_i = 1'b1;
    cyc(1);
    tx_load_i = 1'b0;
    chk("hs_coinc", {7'd0, tx_empty_o}, 8'd0);
    rx_q.push_back(8'h77);
    xfer(8'h77, 8, got);
    chk("hs_coinc_miso", got, 8'h00);
    cyc(4);
    ss_i = 1'b1;
    cyc(6);

    // SS abort after 5 bits
    load(8'h5C);
    ss_i = 1'b0;
    cyc(4);
    load(8'h6D);
    xfer(8'hFF, 5, got);
    ss_i = 1'b1;
    cyc(6);
    chk("abort_busy", {7'd0, busy_o}, 8'd0);
    chk("abort_oe", {7'd0, miso_oe_o}, 8'd0);
    chk("abort_hold", {7'd0, tx_empty_o}, 8'd0);
    frame("post_abort", 8'h3A, 8'h6D, -1);

    // Reset during bit 4
    load(8'h12);
    ss_i = 1'b0;
    cyc(4);
    xfer(8'hFF, 4, got);
    mosi_i = 1'b1;
    cyc(3);
    #2;
    PRESET_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    ss_i = 1'b1;
    sclk_i = cpol_i;
    mosi_i = 1'b0;
    cyc(2);
    PRESET_n = 1'b1;
    cyc(4);
    load(8'h34);
    frame("post_rst", 8'h96, 8'h34, -1);

    cyc(10);
    chk("rx_pending", 8'(rx_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_shifter.md
# spi_slave_shifter

SPI responder (slave-side) shift engine, the far end of the link clocked by `spi_baud_generator`. It receives an externally generated SCLK, SS and MOSI and oversamples them on PCLK. It shifts 8-bit frames in all four CPOL/CPHA modes, drives MISO from a single-entry transmit holding register, and presents each received byte with a one-cycle valid pulse.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth on `sclk_i`, `ss_i`, `mosi_i`; legal values 2–3.

Ports:
- `PCLK`, input, 1: system clock; all logic is on its rising edge.
- `PRESET_n`, input, 1: asynchronous, active-low reset.
- `spe_i`, input, 1: block enable; 0 forces IDLE.
- `cpol_i`, input, 1: clock polarity.
- `cpha_i`, input, 1: clock phase.
- `lsbfe_i`, input, 1: 1 = LSB first, 0 = MSB first.
- `sclk_i`, input, 1: external SPI clock, asynchronous to PCLK.
- `ss_i`, input, 1: slave select, active low, asynchronous.
- `mosi_i`, input, 1: serial data in, asynchronous.
- `miso_o`, output, 1: serial data out.
- `miso_oe_o`, output, 1: MISO output enable.
- `tx_data_i`, input, 8: byte to transmit.
- `tx_load_i`, input, 1: write strobe for `tx_data_i`.
- `tx_empty_o`, output, 1: transmit holding register is empty.
- `rx_data_o`, output, 8: last complete received byte.
- `rx_valid_o`, output, 1: one-PCLK pulse; `rx_data_o` was updated.
- `busy_o`, output, 1: a frame is in progress.

## Operation
- **Reset values:**
  - `miso_o`=0, `miso_oe_o`=0, `tx_empty_o`=1, `rx_data_o`=8'h00, `rx_valid_o`=0, `busy_o`=0.
  - State = IDLE, bit counter = 0, holding register = 8'h00.
- **Input conditioning:** each of `sclk_i`, `ss_i`, `mosi_i` passes through a `SYNC_STAGES`-flop synchronizer. Edges are detected by comparing the synchronized value with a one-cycle-delayed copy.
- **Mode latch:** `cpol`, `cpha` and `lsbfe` are captured on the SS falling edge and held for the whole selection period. Changes mid-frame have no effect.
- **Edge roles:**
  - Leading edge = rising if CPOL=0, falling if CPOL=1. Trailing edge = the opposite.
  - CPHA=0: sample on leading, shift out on trailing.
  - CPHA=1: shift out on leading, sample on trailing.
- **FSM states:**
  - **IDLE:** `busy_o`=0 and `miso_oe_o`=0.
    - Go to LOAD on synchronized SS falling edge with `spe_i`=1.
  - **LOAD:** lasts one cycle.
    - Move the holding register into the shift register, or 8'h00 if `tx_empty_o`=1 (underrun). Set `tx_empty_o`=1.
    - Clear the bit counter.
    - If CPHA=0, present the first bit on `miso_o` immediately.
    - Set `miso_oe_o`=1, go to SHIFT.
  - **SHIFT:**
    - Each sample edge: capture `mosi` into the receive shift register and increment the bit counter.
    - Each drive edge: advance `miso_o`. With CPHA=1 the first leading edge presents bit 0.
    - After the 8th sample: `rx_data_o` ← assembled byte, pulse `rx_valid_o`.
    - If SS is still low, reload as in LOAD at the 8th sample edge so the next frame continues back-to-back.
- **Bit order:** with `lsbfe`=1, the first bit on the wire is bit 0 in both directions; otherwise bit 7 goes first.
- **Transmit holding register:**
  - `tx_load_i` is accepted only when `tx_empty_o`=1 at that edge; it writes the holding register and clears `tx_empty_o`.
  - A load while full is ignored.
  - A load in the same cycle as a LOAD transfer (holding register already empty): the transfer uses underrun data and the new byte stays in the holding register, so `tx_empty_o`=0.
- **SS rising edge mid-frame:**
  - Abort and return to IDLE.
  - The partial byte is discarded with no `rx_valid_o`.
  - The holding register is preserved; the byte being shifted out is lost.
- **Disable:** `spe_i`=0 forces IDLE within one cycle with the same effects as an abort.
- **Ignored edges:** SCLK edges while IDLE are ignored.

## Timing
- PCLK must be at least 8× the SCLK frequency. The minimum SCLK half-period is 4 PCLK cycles.
- **Receive latency:** external sample edge → bit captured after `SYNC_STAGES`+1 PCLK. `rx_valid_o` is asserted in the cycle after the 8th capture.
- **MISO update:** `SYNC_STAGES`+1 PCLK after the external drive edge. This is inside the half-period as long as the ratio rule holds.
- `rx_data_o` stays stable until the next `rx_valid_o`.
- `tx_empty_o` rises the cycle after the LOAD transfer.

## Structure
- Shared package `spi_pkg`:
  - FSM state typedef (IDLE, LOAD, SHIFT).
  - Constant `SPI_DATA_W`=8.
  - Underrun constant `SPI_TX_UNDERRUN`=8'h00.
- Sub-module `spi_sync_edge`: parameterized synchronizer plus rise/fall pulse outputs, instantiated three times.

## Test plan
- **Mode 0, MSB first:** master sends 8'hA5 while the holding register holds 8'h3C → `rx_data_o`=8'hA5 with one `rx_valid_o` pulse, and 8'h3C is observed on MISO.
- **All four CPOL/CPHA modes with `lsbfe`=1:** exchange 8'h01/8'h80 in each mode → correct bytes in both directions, and the MISO first-bit timing matches the CPHA rule.
- **Back-to-back frames:** two frames with SS held low, holding register reloaded between them → two `rx_valid_o` pulses. If no second load occurs, the second transmitted byte is 8'h00.
- **SS abort:** deassert SS after 5 bits → no `rx_valid_o`, `busy_o`=0, and the holding-register contents are retained for the next frame.
- **Holding-register handshake:** a `tx_load_i` while `tx_empty_o`=0 is ignored; a load coinciding with a LOAD transfer leaves `tx_empty_o`=0.
- **Reset mid-frame:** assert `PRESET_n`=0 during bit 4 → all outputs return to reset values asynchronously, and the next full frame after release completes correctly.
